// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared credit class encodings, FSM states and default field widths
package fc_pkg;

    localparam int FC_HDR_FIELD_DEF  = 8;
    localparam int FC_DATA_FIELD_DEF = 12;
    localparam int FC_NUM_TYPES_DEF  = 3;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_type_e;

    typedef enum logic [0:0] {
        FC_INIT   = 1'b0,
        FC_ACTIVE = 1'b1
    } fc_state_e;

    function automatic int fc_type_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_tx_credit_gate_if.sv
// rtl/fc_tx_credit_gate_if.sv - InitFC / UpdateFC / TLP request bundle for the credit gate
interface fc_tx_credit_gate_if
    import fc_pkg::*;
#(
    parameter int TW         = fc_type_width(FC_NUM_TYPES_DEF),
    parameter int HDR_FIELD  = FC_HDR_FIELD_DEF,
    parameter int DATA_FIELD = FC_DATA_FIELD_DEF
);
    logic                  init_valid;
    logic [TW-1:0]         init_type;
    logic [HDR_FIELD-1:0]  init_hdr;
    logic [DATA_FIELD-1:0] init_data;

    logic                  upd_valid;
    logic [TW-1:0]         upd_type;
    logic [HDR_FIELD-1:0]  upd_hdr;
    logic [DATA_FIELD-1:0] upd_data;

    logic                  req_valid;
    logic [TW-1:0]         req_type;
    logic [HDR_FIELD-1:0]  req_hdr;
    logic [DATA_FIELD-1:0] req_data;
    logic                  req_ready;

    modport master (
        output init_valid, init_type, init_hdr, init_data,
        output upd_valid, upd_type, upd_hdr, upd_data,
        output req_valid, req_type, req_hdr, req_data,
        input  req_ready
    );

    modport slave (
        input  init_valid, init_type, init_hdr, init_data,
        input  upd_valid, upd_type, upd_hdr, upd_data,
        input  req_valid, req_type, req_hdr, req_data,
        output req_ready
    );

endinterface

// File: rtl/fc_credit_check.sv
// rtl/fc_credit_check.sv - single-field credit test with modular headroom
module fc_credit_check #(
    parameter int FIELD = 8
) (
    input  logic [FIELD-1:0] limit,
    input  logic [FIELD-1:0] consumed,
    input  logic [FIELD-1:0] required,
    input  logic             inf,
    output logic             pass
);
    localparam logic [FIELD-1:0] HALF = {1'b1, {(FIELD-1){1'b0}}};

    logic [FIELD-1:0] headroom;

    // Headroom past half the field range means the request would overrun the limit.
    assign headroom = limit - (consumed + required);
    assign pass     = inf || (headroom <= HALF);

endmodule

// File: rtl/fc_tx_credit_gate.sv
// rtl/fc_tx_credit_gate.sv - transmit-side flow-control credit gate for P/NP/CPL TLPs
module fc_tx_credit_gate
    import fc_pkg::*;
#(
    parameter int HDR_FIELD  = FC_HDR_FIELD_DEF,
    parameter int DATA_FIELD = FC_DATA_FIELD_DEF,
    parameter int NUM_TYPES  = FC_NUM_TYPES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fc_tx_credit_gate_if.slave   bus,
    output logic                 fc_init_done,
    output logic [NUM_TYPES-1:0] blocked
);
    fc_state_e             state;
    logic [NUM_TYPES-1:0]  seen;
    logic [HDR_FIELD-1:0]  hdr_consumed  [NUM_TYPES];
    logic [DATA_FIELD-1:0] data_consumed [NUM_TYPES];
    logic [HDR_FIELD-1:0]  hdr_limit     [NUM_TYPES];
    logic [DATA_FIELD-1:0] data_limit    [NUM_TYPES];
    logic [NUM_TYPES-1:0]  hdr_inf;
    logic [NUM_TYPES-1:0]  data_inf;
    logic [NUM_TYPES-1:0]  hdr_pass;
    logic [NUM_TYPES-1:0]  data_pass;

    logic                  type_ok;
    logic                  zero_req;
    logic                  sel_pass;
    logic                  transfer;
    logic                  refused;
    logic [NUM_TYPES-1:0]  init_hit;
    logic [NUM_TYPES-1:0]  upd_hit;
    logic [NUM_TYPES-1:0]  req_hit;

    for (genvar t = 0; t < NUM_TYPES; t++) begin : g_check
        fc_credit_check #(.FIELD(HDR_FIELD)) u_hdr (
            .limit    (hdr_limit[t]),
            .consumed (hdr_consumed[t]),
            .required (bus.req_hdr),
            .inf      (hdr_inf[t]),
            .pass     (hdr_pass[t])
        );
        fc_credit_check #(.FIELD(DATA_FIELD)) u_data (
            .limit    (data_limit[t]),
            .consumed (data_consumed[t]),
            .required (bus.req_data),
            .inf      (data_inf[t]),
            .pass     (data_pass[t])
        );
    end

    always_comb begin
        sel_pass = 1'b0;
        init_hit = '0;
        upd_hit  = '0;
        req_hit  = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            init_hit[t] = bus.init_valid && (int'(bus.init_type) == t);
            upd_hit[t]  = bus.upd_valid  && (int'(bus.upd_type)  == t);
            req_hit[t]  = bus.req_valid  && (int'(bus.req_type)  == t);
            if (int'(bus.req_type) == t) begin
                sel_pass = hdr_pass[t] && data_pass[t];
            end
        end
    end

    assign type_ok       = int'(bus.req_type) < NUM_TYPES;
    assign zero_req      = (bus.req_hdr == '0) && (bus.req_data == '0);
    // Reset wins in the same cycle so a request on a reset edge is never granted.
    assign bus.req_ready = !rst && (state == FC_ACTIVE) && bus.req_valid && type_ok
                           && (zero_req || sel_pass);
    assign transfer      = bus.req_ready;
    assign refused       = (state == FC_ACTIVE) && bus.req_valid && !bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FC_INIT;
            fc_init_done <= 1'b0;
            seen         <= '0;
            blocked      <= '0;
            hdr_inf      <= '0;
            data_inf     <= '0;
            for (int t = 0; t < NUM_TYPES; t++) begin
                hdr_consumed[t]  <= '0;
                data_consumed[t] <= '0;
                hdr_limit[t]     <= '0;
                data_limit[t]    <= '0;
            end
        end else begin
            case (state)
                FC_INIT: begin
                    if (&seen) begin
                        state        <= FC_ACTIVE;
                        fc_init_done <= 1'b1;
                    end
                    for (int t = 0; t < NUM_TYPES; t++) begin
                        if (init_hit[t]) begin
                            hdr_limit[t]  <= bus.init_hdr;
                            data_limit[t] <= bus.init_data;
                            hdr_inf[t]    <= (bus.init_hdr == '0);
                            data_inf[t]   <= (bus.init_data == '0);
                            seen[t]       <= 1'b1;
                        end
                    end
                end
                FC_ACTIVE: begin
                    for (int t = 0; t < NUM_TYPES; t++) begin
                        if (upd_hit[t] && !hdr_inf[t])  hdr_limit[t]  <= bus.upd_hdr;
                        if (upd_hit[t] && !data_inf[t]) data_limit[t] <= bus.upd_data;
                        if (transfer && req_hit[t]) begin
                            if (!hdr_inf[t])  hdr_consumed[t]  <= hdr_consumed[t] + bus.req_hdr;
                            if (!data_inf[t]) data_consumed[t] <= data_consumed[t] + bus.req_data;
                        end
                        // Fresh credit or a completed send both make the stall stale.
                        if (upd_hit[t] || (transfer && req_hit[t])) begin
                            blocked[t] <= 1'b0;
                        end else if (refused && req_hit[t]) begin
                            blocked[t] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= FC_INIT;
                    fc_init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// tb/tb_fc_tx_credit_gate.sv - directed self-checking bench for fc_tx_credit_gate
module tb_fc_tx_credit_gate;
    import fc_pkg::*;

    logic       clk;
    logic       rst;
    logic       fc_init_done;
    logic [2:0] blocked;

    int n_cmp;
    int n_bad;

    fc_tx_credit_gate_if #(.TW(2), .HDR_FIELD(8), .DATA_FIELD(12)) bus ();

    fc_tx_credit_gate #(.HDR_FIELD(8), .DATA_FIELD(12), .NUM_TYPES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fc_init_done (fc_init_done),
        .blocked      (blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.init_valid = 1'b0; bus.init_type = 2'd0; bus.init_hdr = 8'd0; bus.init_data = 12'd0;
        bus.upd_valid  = 1'b0; bus.upd_type  = 2'd0; bus.upd_hdr  = 8'd0; bus.upd_data  = 12'd0;
        bus.req_valid  = 1'b0; bus.req_type  = 2'd0; bus.req_hdr  = 8'd0; bus.req_data  = 12'd0;
    endtask

    task automatic set_req(input logic v, input logic [1:0] ty, input logic [7:0] h, input logic [11:0] d);
        bus.req_valid = v; bus.req_type = ty; bus.req_hdr = h; bus.req_data = d;
        #1;
    endtask

    task automatic do_init(input logic [7:0] ph, input logic [11:0] pd,
                           input logic [7:0] nh, input logic [11:0] nd,
                           input logic [7:0] ch, input logic [11:0] cd);
        int waited;
        bus.init_valid = 1'b1;
        bus.init_type = FC_P;   bus.init_hdr = ph; bus.init_data = pd; tick();
        bus.init_type = FC_NP;  bus.init_hdr = nh; bus.init_data = nd; tick();
        n_cmp++;
        if (fc_init_done !== 1'b0) begin
            n_bad++; $display("FAIL init_partial_done: got %b expected 0", fc_init_done);
        end
        bus.init_type = FC_CPL; bus.init_hdr = ch; bus.init_data = cd; tick();
        bus.init_valid = 1'b0;
        waited = 0;
        while (fc_init_done !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (fc_init_done !== 1'b1) begin
            n_bad++; $display("FAIL init_done_timeout: got %b expected 1", fc_init_done);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        set_req(1'b1, FC_P, 8'd0, 12'd0);
        n_cmp++;
        if (fc_init_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", fc_init_done); end
        n_cmp++;
        if (blocked !== 3'b000) begin n_bad++; $display("FAIL reset_blocked: got %b expected 000", blocked); end
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL init_ready: got %b expected 0", bus.req_ready); end
        set_req(1'b0, FC_P, 8'd0, 12'd0);
    endtask

    task automatic test_grant_sequence();
        do_init(8'd4, 12'd16, 8'd1, 12'd0, 8'd0, 12'd0);
        set_req(1'b1, FC_P, 8'd1, 12'd4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL p_grant_%0d: got %b expected 1", i, bus.req_ready); end
            tick();
        end
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL p_fifth_refused: got %b expected 0", bus.req_ready); end
        tick();
        n_cmp++;
        if (blocked !== 3'b001) begin n_bad++; $display("FAIL p_blocked: got %b expected 001", blocked); end
    endtask

    task automatic test_update_unblock();
        bus.upd_valid = 1'b1; bus.upd_type = FC_P; bus.upd_hdr = 8'd8; bus.upd_data = 12'd32;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL upd_pre_ready: got %b expected 0", bus.req_ready); end
        tick();
        bus.upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL upd_post_ready: got %b expected 1", bus.req_ready); end
        n_cmp++;
        if (blocked !== 3'b000) begin n_bad++; $display("FAIL upd_unblocked: got %b expected 000", blocked); end
        tick();
        set_req(1'b0, FC_P, 8'd0, 12'd0);
    endtask

    task automatic test_np_and_zero();
        set_req(1'b1, FC_NP, 8'd1, 12'd100);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL np_first: got %b expected 1", bus.req_ready); end
        tick();
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL np_second: got %b expected 0", bus.req_ready); end
        tick();
        n_cmp++;
        if (blocked !== 3'b010) begin n_bad++; $display("FAIL np_blocked: got %b expected 010", blocked); end
        set_req(1'b1, FC_NP, 8'd0, 12'd0);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_credit: got %b expected 1", bus.req_ready); end
        tick();
        n_cmp++;
        if (blocked !== 3'b000) begin n_bad++; $display("FAIL zero_clears_blocked: got %b expected 000", blocked); end
        set_req(1'b1, 2'd3, 8'd0, 12'd0);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bad_type: got %b expected 0", bus.req_ready); end
        set_req(1'b0, FC_P, 8'd0, 12'd0);
    endtask

    task automatic test_back_to_back_cpl();
        int grants;
        grants = 0;
        set_req(1'b1, FC_CPL, 8'd1, 12'd64);
        for (int i = 0; i < 1000; i++) begin
            if (bus.req_ready === 1'b1) grants++;
            tick();
        end
        set_req(1'b0, FC_P, 8'd0, 12'd0);
        n_cmp++;
        if (grants !== 1000) begin n_bad++; $display("FAIL cpl_grants: got %0d expected 1000", grants); end
        n_cmp++;
        if (dut.hdr_consumed[2] !== 8'd0) begin n_bad++; $display("FAIL cpl_hdr_consumed: got %0d expected 0", dut.hdr_consumed[2]); end
        n_cmp++;
        if (dut.data_consumed[2] !== 12'd0) begin n_bad++; $display("FAIL cpl_data_consumed: got %0d expected 0", dut.data_consumed[2]); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        do_init(8'd250, 12'd0, 8'd1, 12'd0, 8'd0, 12'd0);
        set_req(1'b1, FC_P, 8'd125, 12'd7);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_fill_%0d: got %b expected 1", i, bus.req_ready); end
            tick();
        end
        set_req(1'b0, FC_P, 8'd0, 12'd0);
        bus.upd_valid = 1'b1; bus.upd_type = FC_P; bus.upd_hdr = 8'd4; bus.upd_data = 12'd0;
        tick();
        bus.upd_valid = 1'b0;
        set_req(1'b1, FC_P, 8'd1, 12'd9);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_grant_%0d: got %b expected 1", i, bus.req_ready); end
            tick();
        end
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_eleventh: got %b expected 0", bus.req_ready); end
    endtask

    task automatic test_same_cycle_update();
        bus.upd_valid = 1'b1; bus.upd_type = FC_P; bus.upd_hdr = 8'd6; bus.upd_data = 12'd0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL same_cycle_old: got %b expected 0", bus.req_ready); end
        tick();
        bus.upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL same_cycle_new: got %b expected 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_reset_active();
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL pre_reset_ready: got %b expected 1", bus.req_ready); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_same_cycle: got %b expected 0", bus.req_ready); end
        tick();
        n_cmp++;
        if (fc_init_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", fc_init_done); end
        n_cmp++;
        if (dut.hdr_consumed[0] !== 8'd0) begin n_bad++; $display("FAIL rst_consumed: got %0d expected 0", dut.hdr_consumed[0]); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_refused: got %b expected 0", bus.req_ready); end
        do_init(8'd2, 12'd0, 8'd1, 12'd0, 8'd0, 12'd0);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reinit_ready: got %b expected 1", bus.req_ready); end
        set_req(1'b0, FC_P, 8'd0, 12'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_grant_sequence();
        test_update_unblock();
        test_np_and_zero();
        test_back_to_back_cpl();
        test_wrap();
        test_same_cycle_update();
        test_reset_active();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
